// File: rtl/pipe_ifid_queue_if.sv
// Fetch/decode handshake bundle for the IF/ID prefetch queue.
//   master : fetch + decode side (drives if_*, flush, id_ready; observes the rest)
//   slave  : the queue itself
// AW is the queue pointer width; count is AW+1 bits wide (0..DEPTH).
interface pipe_ifid_queue_if #(
    parameter int unsigned AW = 2
);
    logic          if_valid;
    logic [31:0]   if_ins;
    logic [31:0]   if_pc4;
    logic          if_ready;
    logic          flush;
    logic          id_ready;
    logic          id_valid;
    logic [31:0]   id_ins;
    logic [31:0]   id_pc4;
    logic [AW:0]   count;

    modport master (
        output if_valid, if_ins, if_pc4, flush, id_ready,
        input  if_ready, id_valid, id_ins, id_pc4, count
    );

    modport slave (
        input  if_valid, if_ins, if_pc4, flush, id_ready,
        output if_ready, id_valid, id_ins, id_pc4, count
    );
endinterface

// File: rtl/pipe_ifid_queue.sv
// Instruction prefetch queue between fetch and decode.
// Buffers {instruction, PC+4} pairs in order, absorbs decode stalls, and is
// emptied by a taken branch/jump (flush).
// Ports:
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   q (slave)    : if_valid/if_ins/if_pc4/if_ready push side,
//                  id_valid/id_ins/id_pc4/id_ready pop side, flush, count
module pipe_ifid_queue #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic              clock,
    input  logic              reset,
    pipe_ifid_queue_if.slave  q
);
    localparam int unsigned CW = AW + 1;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc4;
    } entry_t;

    entry_t          mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [CW-1:0]   count;

    logic            full_c;
    logic            empty_c;
    logic            push_c;
    logic            pop_c;
    entry_t          head_c;

    // Status from registered count only; no path from id_ready to if_ready.
    assign full_c  = (count == CW'(DEPTH));
    assign empty_c = (count == CW'(0));

    // Flush suppresses both sides; a full queue refuses a push even when popping.
    assign push_c = q.if_valid & ~full_c & ~q.flush;
    assign pop_c  = q.id_ready & ~empty_c & ~q.flush;

    // Pointers and occupancy.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (q.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            if (push_c && !pop_c)      count <= count + CW'(1);
            else if (pop_c && !push_c) count <= count - CW'(1);
        end
    end

    // Entry storage; contents are don't-care after reset, so no reset term.
    always_ff @(posedge clock) begin
        if (push_c) mem[wr_ptr] <= '{ins: q.if_ins, pc4: q.if_pc4};
    end

    // Head is read from storage (no fall-through) and zeroed when empty.
    always_comb begin
        head_c = '0;
        if (!empty_c) head_c = mem[rd_ptr];
    end

    assign q.if_ready = ~full_c;
    assign q.id_valid = ~empty_c;
    assign q.id_ins   = head_c.ins;
    assign q.id_pc4   = head_c.pc4;
    assign q.count    = count;
endmodule

// File: tb/tb_pipe_ifid_queue.sv
// Directed self-checking bench for pipe_ifid_queue (DEPTH=4).
module tb_pipe_ifid_queue;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned AW    = 2;

    logic clock;
    logic reset;
    int   checks;
    int   errors;

    pipe_ifid_queue_if #(.AW(AW)) bus ();

    pipe_ifid_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clock (clock),
        .reset (reset),
        .q     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc4);
        bus.if_valid = v;
        bus.if_ins   = ins;
        bus.if_pc4   = pc4;
    endtask

    task automatic idle_inputs();
        drive(1'b0, 32'h0, 32'h0);
        bus.flush    = 1'b0;
        bus.id_ready = 1'b0;
    endtask

    task automatic clear_queue();
        idle_inputs();
        bus.flush = 1'b1;
        step();
        bus.flush = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #2;
        checks++; if (bus.count !== 3'd0)    begin errors++; $display("FAIL reset_count: got %0d expected 0", bus.count); end
        checks++; if (bus.id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", bus.id_valid); end
        checks++; if (bus.if_ready !== 1'b1) begin errors++; $display("FAIL reset_if_ready: got %b expected 1", bus.if_ready); end
        step(); step();
        reset = 1'b0;
        step();
        checks++; if (bus.id_ins !== 32'h0 || bus.id_pc4 !== 32'h0) begin errors++; $display("FAIL idle_head: got %h/%h expected 0/0", bus.id_ins, bus.id_pc4); end
        checks++; if (bus.count !== 3'd0 || bus.if_ready !== 1'b1) begin errors++; $display("FAIL idle_status: got count=%0d rdy=%b expected 0/1", bus.count, bus.if_ready); end
    endtask

    task automatic test_stall_push();
        clear_queue();
        bus.id_ready = 1'b0;
        drive(1'b1, 32'h20010005, 32'h4);
        step();
        checks++; if (bus.id_valid !== 1'b1 || bus.id_ins !== 32'h20010005 || bus.id_pc4 !== 32'h4) begin errors++; $display("FAIL stall_first_head: got v=%b %h/%h expected 1 20010005/00000004", bus.id_valid, bus.id_ins, bus.id_pc4); end
        drive(1'b1, 32'h20020007, 32'h8);
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (bus.count !== 3'd2) begin errors++; $display("FAIL stall_count: got %0d expected 2", bus.count); end
        step(); step();
        checks++; if (bus.id_ins !== 32'h20010005 || bus.id_pc4 !== 32'h4 || bus.count !== 3'd2) begin errors++; $display("FAIL stall_hold: got %h/%h cnt=%0d expected 20010005/00000004 cnt=2", bus.id_ins, bus.id_pc4, bus.count); end
    endtask

    task automatic test_full();
        logic [31:0] a [5];
        int sent;
        int got;
        for (int i = 0; i < 5; i++) a[i] = 32'hA000_0000 + 32'(i);
        clear_queue();
        bus.id_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, a[i], 32'(4 * (i + 1)));
            step();
        end
        drive(1'b1, a[4], 32'd20);
        checks++; if (bus.count !== 3'd4 || bus.if_ready !== 1'b0) begin errors++; $display("FAIL full_status: got cnt=%0d rdy=%b expected 4/0", bus.count, bus.if_ready); end
        step();
        checks++; if (bus.count !== 3'd4 || bus.id_ins !== a[0]) begin errors++; $display("FAIL full_refuse: got cnt=%0d head=%h expected 4/%h", bus.count, bus.id_ins, a[0]); end
        // Pop while full with a push offered: push must be refused.
        bus.id_ready = 1'b1;
        step();
        checks++; if (bus.count !== 3'd3 || bus.if_ready !== 1'b1) begin errors++; $display("FAIL full_pop_push: got cnt=%0d rdy=%b expected 3/1", bus.count, bus.if_ready); end
        checks++; if (bus.id_ins !== a[1]) begin errors++; $display("FAIL full_pop_head: got %h expected %h", bus.id_ins, a[1]); end
        sent = 4;
        got  = 1;
        for (int cyc = 0; cyc < 12 && got < 5; cyc++) begin
            checks++; if (bus.id_valid !== 1'b1 || bus.id_ins !== a[got]) begin errors++; $display("FAIL full_drain_%0d: got v=%b %h expected 1 %h", got, bus.id_valid, bus.id_ins, a[got]); end
            if (sent < 5 && bus.if_ready === 1'b1) begin
                step();
                sent++;
                drive(1'b0, 32'h0, 32'h0);
            end else begin
                step();
            end
            got++;
        end
        checks++; if (got !== 5 || bus.count !== 3'd0) begin errors++; $display("FAIL full_drain_done: got delivered=%0d cnt=%0d expected 5/0", got, bus.count); end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        logic [31:0] w;
        logic [31:0] p;
        clear_queue();
        bus.id_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            w = 32'h1000_0000 + 32'(i);
            p = 32'(4 * (i + 1));
            drive(1'b1, w, p);
            step();
            checks++; if (bus.id_ins !== w || bus.id_pc4 !== p || bus.count !== 3'd1) begin errors++; $display("FAIL b2b_%0d: got %h/%h cnt=%0d expected %h/%h cnt=1", i, bus.id_ins, bus.id_pc4, bus.count, w, p); end
        end
        drive(1'b0, 32'h0, 32'h0);
        step();
        checks++; if (bus.count !== 3'd0 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain: got cnt=%0d v=%b expected 0/0", bus.count, bus.id_valid); end
        idle_inputs();
    endtask

    task automatic test_flush();
        clear_queue();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h3000_0000 + 32'(i), 32'(i));
            step();
        end
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL flush_pre_count: got %0d expected 3", bus.count); end
        drive(1'b1, 32'h08000010, 32'h40);
        bus.flush    = 1'b1;
        bus.id_ready = 1'b1;
        step();
        drive(1'b0, 32'h0, 32'h0);
        bus.flush = 1'b0;
        checks++; if (bus.count !== 3'd0 || bus.id_valid !== 1'b0 || bus.id_ins !== 32'h0 || bus.if_ready !== 1'b1) begin errors++; $display("FAIL flush_state: got cnt=%0d v=%b ins=%h rdy=%b expected 0/0/0/1", bus.count, bus.id_valid, bus.id_ins, bus.if_ready); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++; if (bus.id_valid !== 1'b0 || bus.id_ins === 32'h08000010) begin errors++; $display("FAIL flush_discard_%0d: got v=%b ins=%h expected v=0 ins!=08000010", i, bus.id_valid, bus.id_ins); end
        end
        idle_inputs();
    endtask

    task automatic test_empty_and_nop();
        clear_queue();
        bus.id_ready = 1'b1;
        step();
        checks++; if (bus.count !== 3'd0 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL empty_pop: got cnt=%0d v=%b expected 0/0", bus.count, bus.id_valid); end
        bus.id_ready = 1'b0;
        drive(1'b1, 32'h0, 32'h44);
        step();
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (bus.id_valid !== 1'b1 || bus.id_ins !== 32'h0 || bus.id_pc4 !== 32'h44 || bus.count !== 3'd1) begin errors++; $display("FAIL nop_store: got v=%b %h/%h cnt=%0d expected 1 00000000/00000044 cnt=1", bus.id_valid, bus.id_ins, bus.id_pc4, bus.count); end
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        clear_queue();
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 32'h5000_0000 + 32'(i), 32'h100 + 32'(i));
            step();
        end
        drive(1'b0, 32'h0, 32'h0);
        checks++; if (bus.count !== 3'd3) begin errors++; $display("FAIL rstmid_pre: got %0d expected 3", bus.count); end
        reset = 1'b1;
        #1;
        checks++; if (bus.count !== 3'd0 || bus.id_valid !== 1'b0 || bus.id_ins !== 32'h0 || bus.id_pc4 !== 32'h0 || bus.if_ready !== 1'b1) begin errors++; $display("FAIL rstmid_async: got cnt=%0d v=%b %h/%h rdy=%b expected 0/0/0/0/1", bus.count, bus.id_valid, bus.id_ins, bus.id_pc4, bus.if_ready); end
        step();
        reset = 1'b0;
        step();
        checks++; if (bus.count !== 3'd0 || bus.id_valid !== 1'b0) begin errors++; $display("FAIL rstmid_after: got cnt=%0d v=%b expected 0/0", bus.count, bus.id_valid); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        idle_inputs();
        test_reset();
        test_stall_push();
        test_full();
        test_back_to_back();
        test_flush();
        test_empty_and_nop();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/pipe_ifid_queue.md
Name: pipe_ifid_queue

Overview:
- Instruction prefetch queue between the fetch stage and the decode stage of the 5-stage MIPS pipeline.
- Accepts one fetched instruction and its PC+4 per cycle and presents them in order to decode.
- Absorbs decode stalls, so fetch stops only when the queue is full.
- Discards all queued entries when a taken branch or jump redirects the PC.

Parameters:
- DEPTH, 4, number of entries; power of two, minimum 2.
- AW, 2, pointer width; must equal log2(DEPTH).

Ports:
- clock  input  1  pipeline clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- if_valid  input  1  fetch presents a valid instruction this cycle.
- if_ins  input  32  fetched instruction word; 0 is a nop.
- if_pc4  input  32  PC+4 of the fetched instruction.
- if_ready  output  1  queue can accept a push this cycle.
- flush  input  1  taken branch or jump in decode (pcsource != 0); empties the queue.
- id_ready  input  1  decode consumes the head this cycle (not stalled).
- id_valid  output  1  head entry is valid.
- id_ins  output  32  head instruction; 0 when id_valid=0.
- id_pc4  output  32  head PC+4; 0 when id_valid=0.
- count  output  AW+1  number of valid entries, 0..DEPTH.

Behaviour:
- Reset: asynchronous and active-high. While reset=1 and after release:
  - wr_ptr=0, rd_ptr=0, count=0.
  - id_valid=0, id_ins=0, id_pc4=0.
  - if_ready=1.
  - Reset asserted mid-operation drops every entry immediately; entry storage contents are don't-care.
- Storage: DEPTH x 64-bit register array holding {ins, pc4}. Pointers are AW bits and wrap modulo DEPTH naturally.
- Push:
  - push = if_valid & if_ready & ~flush.
  - On push, the entry is written at wr_ptr and wr_ptr increments.
- Pop:
  - pop = id_ready & id_valid & ~flush.
  - On pop, rd_ptr increments.
- Readiness: if_ready = (count != DEPTH). It is derived from registered count only, with no combinational path from id_ready.
  - When the queue is full, a push is refused even in a cycle where a pop occurs.
- Count update: push only: +1. Pop only: -1. Push and pop together: unchanged, and both pointers advance.
- Latency and head outputs:
  - A pushed entry becomes visible at the head on the cycle after the push edge.
  - There is no fall-through bypass; minimum latency from push to decode is 1 cycle.
  - id_valid = (count != 0).
  - id_ins and id_pc4 are driven from storage[rd_ptr], gated to 0 when count == 0.
- Flush:
  - Highest priority. At the edge: rd_ptr=wr_ptr=0 and count=0.
  - The same-cycle push and pop are both suppressed; the instruction on if_ins that cycle is discarded.
  - From the next cycle: id_valid=0, id_ins=0, if_ready=1.
- Empty: id_ready with count=0 has no effect; pointers hold.
- Full: if_valid with count=DEPTH has no effect; fetch must hold its PC while if_ready=0.
- Wrap-around: ordering is preserved across pointer wrap. The entry written at index DEPTH-1 is followed by the entry written at index 0.
- Nop words: if_ins=0 with if_valid=1 is stored and delivered like any other instruction, with no special-casing.

Test Plan:
- Reset then idle → id_valid=0, id_ins=0, id_pc4=0, count=0, if_ready=1. Assert reset mid-stream with count=3 → all of these restored immediately, before any clock edge.
- Push 0x20010005/pc4 0x4, then 0x20020007/pc4 0x8, with id_ready=0 → count=2. id_ins=0x20010005 and id_pc4=0x4 from the cycle after the first push, held while stalled.
- id_ready=0, push 5 consecutive words A0..A4 with DEPTH=4 → A0..A3 accepted, count=4, if_ready=0, A4 refused and held by fetch. Then id_ready=1 → A0..A4 delivered in order.
- id_ready=1 and if_valid=1 continuously over 12 words (wraps pointers 3x) → delivery order matches push order, each word one cycle after its push, count steady at 1.
- count=3, assert flush for one cycle together with if_valid=1 (word 0x08000010) → next cycle count=0, id_valid=0, id_ins=0, and 0x08000010 never appears at id_ins.
- count=4 (full), id_ready=1 and if_valid=1 in the same cycle → pop occurs, push refused, count=3 next cycle, if_ready=1 next cycle.
